addsub_pipe: RTL and testbench

ADDSUB_PIPE -- requirements
Module: addsub_pipe

---
 rtl/addsub_chunk.sv | 30 +++
 rtl/full_adder_1_bit.sv | 11 +
 rtl/addsub_pipe.sv | 141 ++++++++++++++
 tb/tb_addsub_pipe.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_chunk.sv
// CHUNK-bit ripple adder built from full_adder_1_bit cells.
// c_msb_in exposes the carry into the top bit so the caller can derive signed overflow.
module addsub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);
  logic [CHUNK:0] c;

  assign c[0] = cin;

  genvar gi;
  for (gi = 0; gi < CHUNK; gi++) begin : g_bit
    full_adder_1_bit u_fa (
      .a    (a[gi]),
      .b    (b[gi]),
      .cin  (c[gi]),
      .s    (s[gi]),
      .cout (c[gi+1])
    );
  end

  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];
endmodule

// File: rtl/full_adder_1_bit.sv
// Single-bit full adder cell; the building block for every ripple chunk.
module full_adder_1_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/addsub_pipe.sv
// Carry-chunked pipelined adder/subtractor: one CHUNK-bit slice per stage, valid/ready
// at both ends, and a single global advance enable so the whole pipe stalls as one.
module addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);
  localparam int STAGES = WIDTH / CHUNK;
  // Still-unadded b bits shrink by CHUNK per stage; they are packed back to back here.
  localparam int REM_TOT = (STAGES - 1) * WIDTH - CHUNK * (STAGES - 1) * STAGES / 2;
  localparam int REM_W   = (REM_TOT > 0) ? REM_TOT : 1;
  localparam int SUB_W   = (STAGES > 1) ? STAGES - 1 : 1;

  logic              advance;
  logic [STAGES-1:0] valid_stage;
  logic [STAGES-1:0] carry_stage;
  logic [WIDTH-1:0]  word_stage [STAGES];
  logic [SUB_W-1:0]  sub_stage;
  logic [REM_W-1:0]  rem_stage;
  logic              overflow_reg;

  assign advance   = !valid_stage[STAGES-1] || out_ready;
  assign in_ready  = advance;
  assign out_valid = valid_stage[STAGES-1];
  assign sum       = word_stage[STAGES-1];
  assign carry     = carry_stage[STAGES-1];
  assign overflow  = overflow_reg;

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO = gi * CHUNK;

    logic             v_in;
    logic             s_in;
    logic             c_in;
    logic [WIDTH-1:0] w_in;
    logic [WIDTH-1:0] w_next;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic             c_out;
    logic             msb_in;
    logic             v_reg;
    logic             c_reg;
    logic [WIDTH-1:0] w_reg;

    if (gi == 0) begin : g_head
      // Subtraction enters as a carry-in of 1 against the inverted b.
      assign v_in    = in_valid;
      assign s_in    = sub;
      assign c_in    = sub;
      assign w_in    = a;
      assign b_chunk = b[CHUNK-1:0];
    end else begin : g_body
      localparam int PREV_OFF = (gi - 1) * WIDTH - CHUNK * (gi - 1) * gi / 2;
      assign v_in    = valid_stage[gi-1];
      assign s_in    = sub_stage[gi-1];
      assign c_in    = carry_stage[gi-1];
      assign w_in    = word_stage[gi-1];
      assign b_chunk = rem_stage[PREV_OFF +: CHUNK];
    end

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a        (w_in[LO +: CHUNK]),
      .b        (b_chunk ^ {CHUNK{s_in}}),
      .cin      (c_in),
      .s        (s_chunk),
      .cout     (c_out),
      .c_msb_in (msb_in)
    );

    // The word holds finished sum bits below LO and raw a bits above; this slice swaps in.
    always_comb begin
      w_next              = w_in;
      w_next[LO +: CHUNK] = s_chunk;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_reg <= 1'b0;
        c_reg <= 1'b0;
        w_reg <= '0;
      end else if (advance) begin
        v_reg <= v_in;
        c_reg <= c_out;
        w_reg <= w_next;
      end
    end

    assign valid_stage[gi] = v_reg;
    assign carry_stage[gi] = c_reg;
    assign word_stage[gi]  = w_reg;

    if (gi < STAGES - 1) begin : g_fwd
      localparam int OFF   = gi * WIDTH - CHUNK * gi * (gi + 1) / 2;
      localparam int REM_K = WIDTH - (gi + 1) * CHUNK;
      logic [REM_K-1:0] rem_in;
      logic [REM_K-1:0] rem_reg;
      logic             sub_reg;

      if (gi == 0) begin : g_from_port
        assign rem_in = b[WIDTH-1:CHUNK];
      end else begin : g_from_stage
        localparam int PREV_OFF = (gi - 1) * WIDTH - CHUNK * (gi - 1) * gi / 2;
        assign rem_in = rem_stage[PREV_OFF + CHUNK +: REM_K];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sub_reg <= 1'b0;
          rem_reg <= '0;
        end else if (advance) begin
          sub_reg <= s_in;
          rem_reg <= rem_in;
        end
      end

      assign sub_stage[gi]          = sub_reg;
      assign rem_stage[OFF +: REM_K] = rem_reg;
    end else begin : g_tail
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          overflow_reg <= 1'b0;
        end else if (advance) begin
          overflow_reg <= msb_in ^ c_out;
        end
      end
    end
  end
endmodule

// File: tb/tb_addsub_pipe.sv
// Randomized and directed checks of addsub_pipe against an arithmetic reference model
// with an in-order scoreboard, stall/hold checks and reset flushing.
module tb_addsub_pipe;
  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int STAGES = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  addsub_pipe #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;
    int               acc;
  } op_t;

  op_t              exp_q[$];
  op_t              e_mon;
  int               cyc = 0;
  int               n_vec = 0;
  int               n_bad = 0;
  int               n_done = 0;
  bit               lat_check = 0;
  bit               rand_run = 0;
  bit               held = 0;
  logic [WIDTH-1:0] h_sum;
  logic             h_c;
  logic             h_v;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference: plain integer arithmetic, modulo 2^WIDTH; carry means "no borrow" on sub.
  function automatic op_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                input logic s, input int when);
    op_t o;
    int  ux, uy, sx, sy, r, sr;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      r   = ux - uy;
      o.c = (ux >= uy);
      sr  = sx - sy;
    end else begin
      r   = ux + uy;
      o.c = (r >= (1 << WIDTH));
      sr  = sx + sy;
    end
    o.a   = x;
    o.b   = y;
    o.sub = s;
    o.s   = r[WIDTH-1:0];
    o.v   = (sr > (1 << (WIDTH - 1)) - 1) || (sr < -(1 << (WIDTH - 1)));
    o.acc = when;
    return o;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      held = 0;
    end else begin
      if (held) begin
        check("hold_valid", 32'(out_valid), 32'(1'b1));
        check("hold_sum", 32'(sum), 32'(h_sum));
        check("hold_carry", 32'(carry), 32'(h_c));
        check("hold_overflow", 32'(overflow), 32'(h_v));
      end
      check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_result", 32'(out_valid), 32'(1'b0));
        end else begin
          e_mon = exp_q.pop_front();
          check("sum", 32'(sum), 32'(e_mon.s));
          check("carry", 32'(carry), 32'(e_mon.c));
          check("overflow", 32'(overflow), 32'(e_mon.v));
          if (lat_check) check("latency", 32'(cyc - e_mon.acc), 32'(STAGES));
          $display("result %0d: %h %s %h -> sum=%h carry=%b ovf=%b", n_done, e_mon.a,
                   e_mon.sub ? "-" : "+", e_mon.b, sum, carry, overflow);
          n_done++;
        end
      end
      held  = out_valid && !out_ready;
      h_sum = sum;
      h_c   = carry;
      h_v   = overflow;
      if (in_valid && in_ready) exp_q.push_back(model(a, b, sub, cyc));
    end
  end

  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
    int guard = 0;
    in_valid = 1'b1;
    a        = x;
    b        = y;
    sub      = s;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("accept_timeout", 32'(guard), 32'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 16'($urandom);
    b        = 16'($urandom);
    sub      = 1'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    idle(STAGES + 2);
    check("drain_empty", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic send_rand();
    send(16'($urandom), 16'($urandom), 1'($urandom));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    out_ready = 1'b1;
    idle(2);
    check("reset_out_valid", 32'(out_valid), 32'(1'b0));
    check("reset_sum", 32'(sum), 32'(0));
    check("reset_carry", 32'(carry), 32'(1'b0));
    check("reset_overflow", 32'(overflow), 32'(1'b0));
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(in_ready), 32'(1'b1));
    idle(1);

    // Directed corner cases, each must arrive exactly STAGES cycles after acceptance.
    lat_check = 1;
    send(16'h00FF, 16'h0001, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0);
    send(16'h0005, 16'h0003, 1'b1);
    send(16'h0003, 16'h0005, 1'b1);
    send(16'h8000, 16'h0001, 1'b1);
    drain();

    // Six back-to-back ops with the consumer stalling for three cycles.
    lat_check = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send_rand();
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with work in flight and a result sitting at the output.
    lat_check = 1;
    for (int i = 0; i < 4; i++) send_rand();
    #1 rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'(1'b0));
    check("async_rst_sum", 32'(sum), 32'(0));
    check("async_rst_carry", 32'(carry), 32'(1'b0));
    check("async_rst_overflow", 32'(overflow), 32'(1'b0));
    exp_q.delete();
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset2", 32'(in_ready), 32'(1'b1));
    idle(STAGES + 3);
    send_rand();
    drain();

    // Alternating in_valid: every result followed by a one-cycle bubble.
    for (int i = 0; i < 4; i++) begin
      send_rand();
      idle(1);
    end
    drain();

    // Random traffic with random backpressure.
    lat_check = 0;
    rand_run  = 1;
    fork
      begin
        while (rand_run) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 200; i++) begin
      send_rand();
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_run = 0;
    repeat (2) @(posedge clk);
    #2;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d results outstanding", exp_q.size());
    $fatal(1, "simulation time limit");
  end
endmodule
